// File: rtl/legv8_cpu.sv
// -----------------------------------------------------------------------------
// legv8_cpu
//
// Minimal multicycle 64-bit LEGv8-subset processor. It holds the PC, IR, a
// 31-entry general register file (X31/XZR is not stored and always reads 0),
// a 64-bit ALU, a unified 4096 x 64 word-addressed RAM and a two-state control
// FSM (FETCH, EXECUTE). Each instruction takes exactly two cycles.
//
// Ports:
//   clk     in   1   system clock, all state updates on the rising edge
//   rst     in   1   asynchronous active-high reset
//   status  out  4   flag register {V, C, N, Z}
//
// Hierarchically visible storage: mem[0:4095] (RAM, not reset) and
// regs[0:30] (X0..X30).
//
// Configuration macro:
//   LEGV8_BRANCH_EN  when defined, B / CBZ / CBNZ are decoded and executed;
//                    otherwise they fall through as NOPs.
// -----------------------------------------------------------------------------
module legv8_cpu (
    input  logic       clk,
    input  logic       rst,
    output logic [3:0] status
);

    localparam logic [11:0] RESET_PC = 12'h800;

    // R-type and D-type opcodes, bits [31:21]
    localparam logic [10:0] OP_ADD   = 11'b10001011000;
    localparam logic [10:0] OP_SUB   = 11'b11001011000;
    localparam logic [10:0] OP_AND   = 11'b10001010000;
    localparam logic [10:0] OP_ORR   = 11'b10101010000;
    localparam logic [10:0] OP_ADDS  = 11'b10101011000;
    localparam logic [10:0] OP_SUBS  = 11'b11101011000;
    localparam logic [10:0] OP_LDUR  = 11'b11111000010;
    localparam logic [10:0] OP_STUR  = 11'b11111000000;
    // I-type opcodes, bits [31:22]
    localparam logic [9:0]  OP_ADDI  = 10'b1001000100;
    localparam logic [9:0]  OP_SUBI  = 10'b1101000100;
    localparam logic [9:0]  OP_ANDI  = 10'b1001001000;
    localparam logic [9:0]  OP_ORRI  = 10'b1011001000;
    localparam logic [9:0]  OP_ADDIS = 10'b1011000100;
    localparam logic [9:0]  OP_SUBIS = 10'b1111000100;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_AND = 2'd2,
        ALU_ORR = 2'd3
    } alu_op_t;

    typedef enum logic {
        S_FETCH   = 1'b0,
        S_EXECUTE = 1'b1
    } state_t;

    state_t      state_reg, state_next;
    logic [11:0] pc_reg, pc_next;
    logic [31:0] ir_reg;
    logic [3:0]  status_reg;

    logic [63:0] mem  [0:4095];
    logic [63:0] regs [0:30];

    // Instruction fields
    logic [4:0]  rd, rn, rm;
    logic [63:0] rn_val, rm_val, rd_val;

    // Decode results
    alu_op_t     alu_op;
    logic        use_imm, alu_wr, set_flags, is_ldur, is_stur;

    // Datapath
    logic [63:0] op_b, b_eff, alu_res, wdata;
    logic [64:0] sum;
    logic [3:0]  alu_flags;
    logic [11:0] d_addr;
    logic [31:0] fetch_word;
    logic        branch_taken;
    logic [11:0] branch_off, branch_target;

    // Control
    logic        ir_load, reg_we, mem_we, flag_we;

    assign status = status_reg;

    assign rd = ir_reg[4:0];
    assign rn = ir_reg[9:5];
    assign rm = ir_reg[20:16];

    // XZR is never stored: index 31 reads as zero.
    assign rn_val = (rn == 5'd31) ? 64'd0 : regs[rn];
    assign rm_val = (rm == 5'd31) ? 64'd0 : regs[rm];
    assign rd_val = (rd == 5'd31) ? 64'd0 : regs[rd];

    assign fetch_word = mem[pc_reg][31:0];

    // D-type address: only the low 12 bits matter, so the sign-extended imm9
    // is added at 12-bit width and wraps naturally.
    assign d_addr = rn_val[11:0] + {{3{ir_reg[20]}}, ir_reg[20:12]};

    // ---------------------------------------------------------------- decode
    always_comb begin
        alu_op    = ALU_ADD;
        use_imm   = 1'b0;
        alu_wr    = 1'b0;
        set_flags = 1'b0;
        is_ldur   = 1'b0;
        is_stur   = 1'b0;
        case (ir_reg[31:21])
            OP_ADD:  alu_wr = 1'b1;
            OP_SUB:  begin alu_wr = 1'b1; alu_op = ALU_SUB; end
            OP_AND:  begin alu_wr = 1'b1; alu_op = ALU_AND; end
            OP_ORR:  begin alu_wr = 1'b1; alu_op = ALU_ORR; end
            OP_ADDS: begin alu_wr = 1'b1; set_flags = 1'b1; end
            OP_SUBS: begin alu_wr = 1'b1; set_flags = 1'b1; alu_op = ALU_SUB; end
            OP_LDUR: is_ldur = 1'b1;
            OP_STUR: is_stur = 1'b1;
            default: ;
        endcase
        // I-type opcodes never collide with the 11-bit ones above.
        case (ir_reg[31:22])
            OP_ADDI:  begin alu_wr = 1'b1; use_imm = 1'b1; end
            OP_SUBI:  begin alu_wr = 1'b1; use_imm = 1'b1; alu_op = ALU_SUB; end
            OP_ANDI:  begin alu_wr = 1'b1; use_imm = 1'b1; alu_op = ALU_AND; end
            OP_ORRI:  begin alu_wr = 1'b1; use_imm = 1'b1; alu_op = ALU_ORR; end
            OP_ADDIS: begin alu_wr = 1'b1; use_imm = 1'b1; set_flags = 1'b1; end
            OP_SUBIS: begin alu_wr = 1'b1; use_imm = 1'b1; set_flags = 1'b1; alu_op = ALU_SUB; end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------- ALU
    always_comb begin
        op_b  = use_imm ? {52'd0, ir_reg[21:10]} : rm_val;
        // Subtraction as A + ~B + 1 so the carry matches the ARM convention.
        b_eff = (alu_op == ALU_SUB) ? ~op_b : op_b;
        sum   = {1'b0, rn_val} + {1'b0, b_eff} + {64'd0, (alu_op == ALU_SUB)};
        case (alu_op)
            ALU_AND: alu_res = rn_val & op_b;
            ALU_ORR: alu_res = rn_val | op_b;
            default: alu_res = sum[63:0];
        endcase
        // Overflow: both adder inputs share a sign that the result lacks.
        alu_flags = {(rn_val[63] == b_eff[63]) && (sum[63] != rn_val[63]),
                     sum[64], sum[63], (sum[63:0] == 64'd0)};
    end

    assign wdata = is_ldur ? mem[d_addr] : alu_res;

    // --------------------------------------------------------------- branches
`ifdef LEGV8_BRANCH_EN
    always_comb begin
        branch_taken = 1'b0;
        branch_off   = 12'd0;
        // Offsets only matter modulo 4096, so the low 12 bits of the
        // sign-extended immediate are its low 12 raw bits.
        if (ir_reg[31:26] == 6'b000101) begin
            branch_taken = 1'b1;
            branch_off   = ir_reg[11:0];
        end else if (ir_reg[31:24] == 8'b10110100) begin
            branch_taken = (rd_val == 64'd0);
            branch_off   = ir_reg[16:5];
        end else if (ir_reg[31:24] == 8'b10110101) begin
            branch_taken = (rd_val != 64'd0);
            branch_off   = ir_reg[16:5];
        end
    end
`else
    assign branch_taken = 1'b0;
    assign branch_off   = 12'd0;
`endif

    // PC was already incremented in FETCH, so step back to the branch itself.
    assign branch_target = pc_reg - 12'd1 + branch_off;

    // -------------------------------------------------------- FSM: state reg
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------ FSM: next state
    always_comb begin
        state_next = S_FETCH;
        case (state_reg)
            S_FETCH:   state_next = S_EXECUTE;
            S_EXECUTE: state_next = S_FETCH;
            default:   state_next = S_FETCH;
        endcase
    end

    // ---------------------------------------------------------- FSM: outputs
    always_comb begin
        ir_load = 1'b0;
        reg_we  = 1'b0;
        mem_we  = 1'b0;
        flag_we = 1'b0;
        pc_next = pc_reg;
        case (state_reg)
            S_FETCH: begin
                ir_load = 1'b1;
                pc_next = pc_reg + 12'd1;
            end
            S_EXECUTE: begin
                reg_we  = alu_wr | is_ldur;
                mem_we  = is_stur;
                flag_we = set_flags;
                if (branch_taken) begin
                    pc_next = branch_target;
                end
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------- datapath state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_reg     <= RESET_PC;
            ir_reg     <= 32'd0;
            status_reg <= 4'b0000;
        end else begin
            pc_reg <= pc_next;
            if (ir_load) begin
                ir_reg <= fetch_word;
            end
            if (flag_we) begin
                status_reg <= alu_flags;
            end
        end
    end

    // Register file: writes to XZR are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 31; i++) begin
                regs[i] <= 64'd0;
            end
        end else if (reg_we && (rd != 5'd31)) begin
            regs[rd] <= wdata;
        end
    end

    // RAM: combinational read above, synchronous write, contents survive reset.
    // A reset during EXECUTE forces the FSM back to FETCH, so mem_we drops.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[d_addr] <= rd_val;
        end
    end

endmodule

// File: tb/tb_legv8_cpu.sv
// -----------------------------------------------------------------------------
// tb_legv8_cpu
//
// Self-checking bench for legv8_cpu. An instruction-level reference model
// (architectural state only: PC, X registers, flags, memory) executes one
// instruction per DUT instruction; after every EXECUTE edge the DUT state is
// compared against it. Directed programs pin the model with literal results,
// then randomized programs exercise all opcodes, flags and memory accesses.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_legv8_cpu;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] status;

    legv8_cpu dut (
        .clk    (clk),
        .rst    (rst),
        .status (status)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [63:0] m_mem [0:4095];
    logic [63:0] m_x   [0:31];
    int          m_pc;
    logic [3:0]  m_status;

    // ------------------------------------------------------------ encoders
    function automatic logic [31:0] enc_r(input logic [10:0] op, input logic [4:0] rm_f,
                                          input logic [4:0] rn_f, input logic [4:0] rd_f);
        return {op, rm_f, 6'd0, rn_f, rd_f};
    endfunction

    function automatic logic [31:0] enc_i(input logic [9:0] op, input logic [11:0] imm,
                                          input logic [4:0] rn_f, input logic [4:0] rd_f);
        return {op, imm, rn_f, rd_f};
    endfunction

    function automatic logic [31:0] enc_d(input logic [10:0] op, input logic [8:0] imm,
                                          input logic [4:0] rn_f, input logic [4:0] rt_f);
        return {op, imm, 2'b00, rn_f, rt_f};
    endfunction

    function automatic logic [31:0] enc_cb(input logic [7:0] op, input logic [18:0] imm,
                                           input logic [4:0] rt_f);
        return {op, imm, rt_f};
    endfunction

    function automatic logic [31:0] enc_b(input logic [25:0] imm);
        return {6'b000101, imm};
    endfunction

    // ------------------------------------------------------------- model
    function automatic logic [63:0] xr(input logic [4:0] idx);
        return (idx == 5'd31) ? 64'd0 : m_x[idx];
    endfunction

    function automatic int sx(input logic [31:0] val, input int bits);
        int r;
        r = int'(val);
        if (val[bits-1]) r = r - (1 << bits);
        return r;
    endfunction

    function automatic logic [3:0] model_flags(input logic [63:0] a, input logic [63:0] b,
                                               input logic [63:0] r, input logic sub);
        logic n, z, c, v;
        logic signed [64:0] s;
        n = r[63];
        z = (r == 64'd0);
        if (sub) begin
            c = (a >= b);
            s = $signed({a[63], a}) - $signed({b[63], b});
        end else begin
            c = (r < a);
            s = $signed({a[63], a}) + $signed({b[63], b});
        end
        v = (s[64] != s[63]);
        return {v, c, n, z};
    endfunction

    task automatic model_reset();
        m_pc = 12'h800;
        m_status = 4'b0000;
        for (int i = 0; i < 32; i++) m_x[i] = 64'd0;
    endtask

    task automatic model_step();
        logic [31:0] ins;
        logic [63:0] a, b, r;
        logic [4:0]  rd_f, rn_f, rm_f;
        logic        wr, fl, sub;
        int          here, ad;
        ins  = m_mem[m_pc][31:0];
        here = m_pc;
        m_pc = (m_pc + 1) % 4096;
        rd_f = ins[4:0];
        rn_f = ins[9:5];
        rm_f = ins[20:16];
        a  = xr(rn_f);
        b  = 64'd0;
        r  = 64'd0;
        wr = 1'b0;
        fl = 1'b0;
        sub = 1'b0;
        ad = (int'(a[11:0]) + sx({23'd0, ins[20:12]}, 9)) & 4095;
        case (ins[31:21])
            11'b10001011000: begin b = xr(rm_f); r = a + b; wr = 1; end
            11'b11001011000: begin b = xr(rm_f); r = a - b; wr = 1; end
            11'b10001010000: begin r = a & xr(rm_f); wr = 1; end
            11'b10101010000: begin r = a | xr(rm_f); wr = 1; end
            11'b10101011000: begin b = xr(rm_f); r = a + b; wr = 1; fl = 1; end
            11'b11101011000: begin b = xr(rm_f); r = a - b; wr = 1; fl = 1; sub = 1; end
            11'b11111000010: begin r = m_mem[ad]; wr = 1; end
            11'b11111000000: m_mem[ad] = xr(rd_f);
            default: ;
        endcase
        b = (ins[31:22] inside {10'b1001000100, 10'b1101000100, 10'b1001001000,
                                10'b1011001000, 10'b1011000100, 10'b1111000100})
            ? {52'd0, ins[21:10]} : b;
        case (ins[31:22])
            10'b1001000100: begin r = a + b; wr = 1; end
            10'b1101000100: begin r = a - b; wr = 1; end
            10'b1001001000: begin r = a & b; wr = 1; end
            10'b1011001000: begin r = a | b; wr = 1; end
            10'b1011000100: begin r = a + b; wr = 1; fl = 1; end
            10'b1111000100: begin r = a - b; wr = 1; fl = 1; sub = 1; end
            default: ;
        endcase
`ifdef LEGV8_BRANCH_EN
        if (ins[31:26] == 6'b000101)
            m_pc = (here + sx({6'd0, ins[25:0]}, 26)) & 4095;
        else if (ins[31:24] == 8'hB4 && xr(rd_f) == 64'd0)
            m_pc = (here + sx({13'd0, ins[23:5]}, 19)) & 4095;
        else if (ins[31:24] == 8'hB5 && xr(rd_f) != 64'd0)
            m_pc = (here + sx({13'd0, ins[23:5]}, 19)) & 4095;
`endif
        if (fl) m_status = model_flags(a, b, r, sub);
        if (wr && rd_f != 5'd31) m_x[rd_f] = r;
    endtask

    // ------------------------------------------------------------ checking
    task automatic expect64(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic check_state(input string tag);
        int bad_reg, bad_addr;
        expect64({tag, ".pc"}, {52'd0, dut.pc_reg}, 64'(m_pc));
        expect64({tag, ".status"}, {60'd0, status}, {60'd0, m_status});
        bad_reg = -1;
        for (int i = 0; i < 31; i++)
            if (bad_reg < 0 && dut.regs[i] !== m_x[i]) bad_reg = i;
        total++;
        if (bad_reg >= 0) begin
            bad++;
            $display("FAIL %s.regs X%0d got=%h want=%h", tag, bad_reg, dut.regs[bad_reg], m_x[bad_reg]);
        end
        bad_addr = -1;
        for (int i = 0; i < 4096; i++)
            if (bad_addr < 0 && dut.mem[i] !== m_mem[i]) bad_addr = i;
        total++;
        if (bad_addr >= 0) begin
            bad++;
            $display("FAIL %s.mem [%0h] got=%h want=%h", tag, bad_addr, dut.mem[bad_addr], m_mem[bad_addr]);
        end
        $display("%s: pc=%h status=%b ir=%h", tag, dut.pc_reg, status, dut.ir_reg);
    endtask

    task automatic load_word(input int addr, input logic [31:0] w);
        dut.mem[addr] = {32'd0, w};
        m_mem[addr]   = {32'd0, w};
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        model_reset();
        expect64("reset.ir", {32'd0, dut.ir_reg}, 64'd0);
        check_state("reset");
        rst = 1'b0;
    endtask

    // One instruction: FETCH edge, then EXECUTE edge.
    task automatic step(input string tag);
        @(posedge clk); #1;
        expect64({tag, ".status_fetch"}, {60'd0, status}, {60'd0, m_status});
        expect64({tag, ".pc_fetch"}, {52'd0, dut.pc_reg}, 64'((m_pc + 1) % 4096));
        model_step();
        @(posedge clk); #1;
        check_state(tag);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [4:0] a, b, c;
        int k;
        a = 5'($urandom_range(0, 31));
        b = 5'($urandom_range(0, 31));
        c = 5'($urandom_range(0, 31));
        k = $urandom_range(0, 15);
        case (k)
            0:  return enc_r(11'b10001011000, a, b, c);
            1:  return enc_r(11'b11001011000, a, b, c);
            2:  return enc_r(11'b10001010000, a, b, c);
            3:  return enc_r(11'b10101010000, a, b, c);
            4:  return enc_r(11'b10101011000, a, b, c);
            5:  return enc_r(11'b11101011000, a, b, c);
            6:  return enc_i(10'b1001000100, 12'($urandom), b, c);
            7:  return enc_i(10'b1101000100, 12'($urandom), b, c);
            8:  return enc_i(10'b1001001000, 12'($urandom), b, c);
            9:  return enc_i(10'b1011001000, 12'($urandom), b, c);
            10: return enc_i(10'b1011000100, 12'($urandom), b, c);
            11: return enc_i(10'b1111000100, 12'($urandom), b, c);
            12: return enc_d(11'b11111000010, 9'($urandom), b, c);
            13: return enc_d(11'b11111000000, 9'($urandom), b, c);
            14: begin
                case ($urandom_range(0, 2))
                    0: return enc_cb(8'hB4, 19'(sx(32'($urandom_range(0, 8)), 32) - 3), a);
                    1: return enc_cb(8'hB5, 19'(sx(32'($urandom_range(0, 8)), 32) - 3), a);
                    default: return enc_b(26'(sx(32'($urandom_range(0, 8)), 32) - 3));
                endcase
            end
            default: return $urandom;
        endcase
    endfunction

    // --------------------------------------------------------------- main
    initial begin
        logic [63:0] v;
        for (int i = 0; i < 4096; i++) begin
            v = {$urandom, $urandom};
            dut.mem[i] = v;
            m_mem[i]   = v;
        end

        // Test-plan program: ADDI / ADDI / STUR / LDUR
        load_word(12'h800, enc_i(10'b1001000100, 12'd7, 5'd31, 5'd2));
        load_word(12'h801, enc_i(10'b1001000100, 12'd14, 5'd2, 5'd3));
        load_word(12'h802, enc_d(11'b11111000000, 9'd14, 5'd2, 5'd3));
        load_word(12'h803, enc_d(11'b11111000010, 9'd0, 5'd3, 5'd1));
        do_reset();
        step("addi_x2"); step("addi_x3"); step("stur"); step("ldur");
        expect64("plan.x2", dut.regs[2], 64'd7);
        expect64("plan.x3", dut.regs[3], 64'd21);
        expect64("plan.mem21", dut.mem[21], 64'd21);
        expect64("plan.x1", dut.regs[1], 64'd21);
        expect64("plan.status", {60'd0, status}, 64'd0);

        // Flags: SUBIS X4,XZR,#0 then ADDIS X5,XZR,#1
        load_word(12'h800, enc_i(10'b1111000100, 12'd0, 5'd31, 5'd4));
        load_word(12'h801, enc_i(10'b1011000100, 12'd1, 5'd31, 5'd5));
        do_reset();
        step("subis");
        expect64("subis.status", {60'd0, status}, 64'b0101);
        expect64("subis.x4", dut.regs[4], 64'd0);
        step("addis");
        expect64("addis.status", {60'd0, status}, 64'b0000);
        expect64("addis.x5", dut.regs[5], 64'd1);

        // XZR is hardwired
        load_word(12'h800, enc_i(10'b1001000100, 12'd9, 5'd31, 5'd6));
        load_word(12'h801, enc_i(10'b1001000100, 12'd5, 5'd31, 5'd31));
        load_word(12'h802, enc_r(11'b10001011000, 5'd31, 5'd31, 5'd6));
        do_reset();
        step("addi_x6"); step("addi_xzr"); step("add_xzr");
        expect64("xzr.x6", dut.regs[6], 64'd0);

        // Branches (NOPs when the feature is compiled out)
        load_word(12'h800, enc_cb(8'hB4, 19'd3, 5'd7));
        do_reset();
        step("cbz_taken");
`ifdef LEGV8_BRANCH_EN
        expect64("cbz_taken.pc", {52'd0, dut.pc_reg}, 64'h803);
`else
        expect64("cbz_taken.pc", {52'd0, dut.pc_reg}, 64'h801);
`endif
        load_word(12'h800, enc_i(10'b1001000100, 12'd1, 5'd31, 5'd7));
        load_word(12'h801, enc_cb(8'hB4, 19'd3, 5'd7));
        load_word(12'h802, enc_b(26'h3FFFFFF));
        do_reset();
        step("addi_x7"); step("cbz_not_taken");
        expect64("cbz_not_taken.pc", {52'd0, dut.pc_reg}, 64'h802);
        step("b_back");
`ifdef LEGV8_BRANCH_EN
        expect64("b_back.pc", {52'd0, dut.pc_reg}, 64'h801);
`else
        expect64("b_back.pc", {52'd0, dut.pc_reg}, 64'h803);
`endif

        // Reset asserted between FETCH and EXECUTE of a STUR
        load_word(12'h800, enc_i(10'b1001000100, 12'd9, 5'd31, 5'd2));
        load_word(12'h801, enc_d(11'b11111000000, 9'd100, 5'd31, 5'd2));
        dut.mem[100] = 64'h1234;
        m_mem[100]   = 64'h1234;
        do_reset();
        step("addi_pre");
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        expect64("rstmid.pc", {52'd0, dut.pc_reg}, 64'h800);
        expect64("rstmid.x2", dut.regs[2], 64'd0);
        expect64("rstmid.ir", {32'd0, dut.ir_reg}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        model_reset();
        expect64("rstmid.mem100", dut.mem[100], 64'h1234);
        check_state("rstmid");
        rst = 1'b0;

        // Undefined opcode
        load_word(12'h800, 32'hFFFF_FFFF);
        do_reset();
        step("undef");
        expect64("undef.pc", {52'd0, dut.pc_reg}, 64'h801);

        // Randomized programs: prime registers from random data, then mix.
        for (int round = 0; round < 6; round++) begin
            for (int r = 0; r < 31; r++)
                load_word(12'h800 + r, enc_d(11'b11111000010, 9'($urandom_range(0, 255)), 5'd31, 5'(r)));
            for (int j = 0; j < 40; j++)
                load_word(12'h800 + 31 + j, rand_instr());
            do_reset();
            for (int j = 0; j < 71; j++)
                step($sformatf("rnd%0d_%0d", round, j));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
